// File: rtl/adc_pkt_buffer.sv
// adc_pkt_buffer: buffers ADC sample words in a FIFO and feeds them to a UDP transmitter, one packet at a time.
// Latency: a popped word appears on tx_data one clock after its tx_req; tx_start_en rises one clock after the FSM sees a full packet queued.
// Backpressure: none toward the ADC; words arriving while the FIFO is full are dropped and counted.
// Optional feature: define ADC_PKT_SEQ_HDR_EN to prepend a {sequence, drop count} header word to each packet.
module adc_pkt_buffer #(
  parameter int DATAWIDTH     = 16,
  parameter int ADC_CHANEL    = 8,
  parameter int WORDS_PER_PKT = 16,
  parameter int FIFO_DEPTH    = 64
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   adc_valid,
  input  logic [ADC_CHANEL*DATAWIDTH-1:0]        adc_data,
  input  logic                                   tx_req,
  input  logic                                   tx_done,
  output logic                                   tx_start_en,
  output logic [15:0]                            tx_byte_num,
  output logic [ADC_CHANEL*DATAWIDTH-1:0]        tx_data,
  output logic [$clog2(FIFO_DEPTH):0]            fifo_level,
  output logic                                   overflow,
  output logic                                   underrun
);

  localparam int W  = ADC_CHANEL * DATAWIDTH;
  localparam int AW = $clog2(FIFO_DEPTH);
`ifdef ADC_PKT_SEQ_HDR_EN
  localparam int NW = WORDS_PER_PKT + 1;
`else
  localparam int NW = WORDS_PER_PKT;
`endif
  localparam logic [15:0] BYTE_NUM = 16'(NW * W / 8);
  localparam logic [15:0] NW_LAST  = 16'(NW - 1);
  localparam logic [AW:0] DEPTH_L  = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0] WPP_L    = (AW+1)'(WORDS_PER_PKT);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    SEND      = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [AW:0]   wr_ptr, rd_ptr;
  logic [W-1:0]  mem [FIFO_DEPTH];
  logic [15:0]   word_cnt;
  logic [31:0]   drop_cnt;
  logic          full, empty;
  logic          push, drop, pop, send_req, req_empty, pkt_begin;
`ifdef ADC_PKT_SEQ_HDR_EN
  logic [31:0]   seq_num;
  logic          hdr_slot;
`endif

  assign fifo_level = wr_ptr - rd_ptr;
  assign full       = (fifo_level == DEPTH_L);
  assign empty      = (fifo_level == '0);

  // Next-state and per-cycle strobes; fullness is judged before any same-cycle pop.
  always_comb begin
    state_d     = state_q;
    push        = adc_valid && !full;
    drop        = adc_valid && full;
    send_req    = (state_q == SEND) && tx_req;
    pop         = 1'b0;
    req_empty   = 1'b0;
    pkt_begin   = 1'b0;
    tx_start_en = (state_q != IDLE);
`ifdef ADC_PKT_SEQ_HDR_EN
    hdr_slot    = send_req && (word_cnt == 16'd0);
    pop         = send_req && !hdr_slot && !empty;
    req_empty   = send_req && !hdr_slot && empty;
`else
    pop         = send_req && !empty;
    req_empty   = send_req && empty;
`endif
    case (state_q)
      IDLE: begin
        if (fifo_level >= WPP_L) begin
          state_d   = START;
          pkt_begin = 1'b1;
        end
      end
      START:     state_d = SEND;
      SEND:      if (send_req && (word_cnt == NW_LAST)) state_d = WAIT_DONE;
      WAIT_DONE: if (tx_done) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FIFO pointers; pointers carry one extra bit so full and empty are distinguishable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // FIFO storage; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= adc_data;
  end

  // Output word register: loads on a pop (or header slot) and otherwise holds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_data <= '0;
    end else begin
`ifdef ADC_PKT_SEQ_HDR_EN
      if (hdr_slot) tx_data <= {seq_num, drop_cnt, {(W-64){1'b0}}};
      else if (pop) tx_data <= mem[rd_ptr[AW-1:0]];
`else
      if (pop) tx_data <= mem[rd_ptr[AW-1:0]];
`endif
    end
  end

  // Packet bookkeeping: byte count latched as the packet opens, request counter for the send phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_byte_num <= '0;
      word_cnt    <= '0;
    end else begin
      if (pkt_begin) begin
        tx_byte_num <= BYTE_NUM;
        word_cnt    <= '0;
      end else if (send_req) begin
        word_cnt <= word_cnt + 16'd1;
      end
    end
  end

  // Sticky error flags and the saturating drop counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
      underrun <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != 32'hFFFF_FFFF) drop_cnt <= drop_cnt + 32'd1;
      end
      if (req_empty) underrun <= 1'b1;
    end
  end

`ifdef ADC_PKT_SEQ_HDR_EN
  // Packet sequence number, bumped as each packet opens so the first packet carries 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            seq_num <= '0;
    else if (pkt_begin) seq_num <= seq_num + 32'd1;
  end
`endif

endmodule

// File: doc/adc_pkt_buffer.md
ADC_PKT_BUFFER -- requirements
Module: adc_pkt_buffer

Interface
REQ-001 Parameter DATAWIDTH, default 16: bits per ADC channel sample.
REQ-002 Parameter ADC_CHANEL, default 8: channels per sample word; word width W = ADC_CHANEL*DATAWIDTH (default 128).
REQ-003 Parameter WORDS_PER_PKT, default 16: payload sample words per UDP packet.
REQ-004 Parameter FIFO_DEPTH, default 64: sample-word FIFO depth; power of 2, at least 2*WORDS_PER_PKT.
REQ-005 clk  input  1  single clock for all logic.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 adc_valid  input  1  adc_data carries a new sample word this cycle.
REQ-008 adc_data  input  W  sample word, channel 0 in the MSBs.
REQ-009 tx_req  input  1  word request from the UDP transmitter.
REQ-010 tx_done  input  1  one-cycle pulse: UDP transmitter finished the frame.
REQ-011 tx_start_en  output  1  packet ready; the transmitter starts on its rising edge.
REQ-012 tx_byte_num  output  16  payload byte count of the current packet.
REQ-013 tx_data  output  W  payload word presented to the transmitter.
REQ-014 fifo_level  output  log2(FIFO_DEPTH)+1  words currently stored.
REQ-015 overflow  output  1  sticky flag: at least one word dropped.
REQ-016 underrun  output  1  sticky flag: tx_req arrived while the FIFO was empty.

Function
REQ-017 A word SHALL be written when adc_valid=1 and fifo_level<FIFO_DEPTH, where fullness is evaluated before any same-cycle pop.
REQ-018 When adc_valid=1 with a full FIFO, the word SHALL be dropped, overflow SHALL set, and the 32-bit drop counter SHALL increment, saturating at 0xFFFFFFFF.
REQ-019 The FSM SHALL have four states: IDLE, START, SEND, WAIT_DONE.
REQ-020 IDLE->START SHALL occur when fifo_level>=WORDS_PER_PKT.
REQ-021 In START, the block SHALL set tx_start_en=1 and latch tx_byte_num = NW*W/8, where NW is the number of words in the packet; the FSM SHALL go to SEND on the next cycle.
REQ-022 tx_start_en SHALL stay 1 through SEND and WAIT_DONE, and SHALL drop to 0 on the cycle after tx_done.
REQ-023 In SEND, each tx_req=1 cycle SHALL pop one word, and tx_data SHALL show that word from the next clock edge onward.
REQ-024 tx_data SHALL hold its value while no pop occurs.
REQ-025 After NW pops, the FSM SHALL go to WAIT_DONE; further tx_req SHALL be ignored and tx_data SHALL hold.
REQ-026 tx_req in IDLE, START or WAIT_DONE SHALL be ignored.
REQ-027 tx_req in SEND with an empty FIFO SHALL set underrun, SHALL NOT pop, SHALL hold tx_data and SHALL still count toward NW.
REQ-028 tx_done in WAIT_DONE SHALL return the FSM to IDLE; tx_done in any other state SHALL be ignored.
REQ-029 The FIFO SHALL keep accepting writes in every state.
REQ-030 Read and write pointers SHALL be log2(FIFO_DEPTH)+1 bits wide and wrap modulo 2*FIFO_DEPTH.
REQ-031 fifo_level SHALL equal the write pointer minus the read pointer.
REQ-032 A simultaneous push and pop SHALL leave fifo_level unchanged.

Reset
REQ-033 With rst=1, the FSM SHALL be in IDLE and both FIFO pointers SHALL be 0.
REQ-034 With rst=1: tx_start_en=0, tx_byte_num=0, tx_data=0, fifo_level=0, overflow=0, underrun=0, drop counter=0, sequence counter=0.
REQ-035 Reset asserted mid-packet SHALL discard all buffered data; the block SHALL restart in IDLE with no pending packet.

Configuration
REQ-036 The feature SHALL be controlled by the macro ADC_PKT_SEQ_HDR_EN.
REQ-037 With ADC_PKT_SEQ_HDR_EN defined, NW = WORDS_PER_PKT+1.
REQ-038 With ADC_PKT_SEQ_HDR_EN defined, the first tx_req of each packet SHALL present a header word instead of popping: {32-bit sequence number, 32-bit drop counter, zero fill to W}.
REQ-039 With ADC_PKT_SEQ_HDR_EN defined, the sequence number SHALL increment by 1, wrapping, on each START.
REQ-040 Without ADC_PKT_SEQ_HDR_EN, NW = WORDS_PER_PKT, every tx_req pops a word, and no header or sequence logic SHALL exist.

Verification
REQ-041 Write 16 words (values 1..16) with defaults -> tx_start_en rises the cycle after the 16th write; tx_byte_num=256; 16 tx_req pulses produce tx_data 1..16 in order, each one cycle after its request.
REQ-042 Write 70 words back-to-back with no tx_req -> the first 64 are stored, fifo_level=64, overflow=1, drop counter=6.
REQ-043 In WAIT_DONE, pulse tx_done while 40 words are queued -> tx_start_en falls, the FSM passes through IDLE, and tx_start_en rises again 2 cycles after tx_done.
REQ-044 Assert rst for 1 cycle during SEND after 5 pops -> all outputs reach their reset values; fifo_level=0.
REQ-045 With ADC_PKT_SEQ_HDR_EN defined, send two packets -> tx_byte_num=272; the first words carry sequence numbers 1 and 2 in bits W-1:W-32.
REQ-046 Issue 3 extra tx_req after the 16th pop -> no pop, fifo_level unchanged, underrun=0, tx_data holds the 16th word.
